// File: rtl/clk_div_detect_pkg.sv
// Shared types and defaults for the divided-clock period detector.
package clk_div_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 4;
    localparam int TIMEOUT_DEF  = 255;
    localparam int MATCH_W      = 4;

    // Run length of identical periods; a zero count means no reference period yet.
    function automatic logic [MATCH_W-1:0] next_match(input logic [MATCH_W-1:0] cur,
                                                      input logic              eq);
        if (eq && (cur != MATCH_W'(0))) begin
            return cur + MATCH_W'(1);
        end else begin
            return MATCH_W'(1);
        end
    endfunction

endpackage

// File: rtl/clk_div_detect_sync_edge_det.sv
// Two-flop synchronizer for the asynchronous din plus rising-edge detect.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s2_d_r;

    // Synchronizer chain and one-cycle history of the synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s2_d_r <= 1'b0;
        end else begin
            s1_r   <= din;
            s2_r   <= s1_r;
            s2_d_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s2_d_r;

endmodule

// File: rtl/clk_div_detect.sv
// Measures the rising-to-rising period of din in clk cycles and detects a stable ratio.
module clk_div_detect
    import clk_div_detect_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic [CNT_W-1:0] ratio,
    output logic             locked,
    output logic             lost,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_CNT);

    logic               rise_s;
    logic               cnt_max_s;
    logic               eq_s;
    logic [MATCH_W-1:0] match_nxt_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   last_r;
    logic [MATCH_W-1:0] match_r;
    state_t             state_r;
    logic [CNT_W-1:0]   period_r;
    logic               period_vld_r;
    logic [CNT_W-1:0]   ratio_r;
    logic               locked_r;
    logic               lost_r;
    logic               timeout_r;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .rise (rise_s)
    );

    // Compare the running count against saturation and the reference period.
    always_comb begin
        cnt_max_s   = (cnt_r == CNT_MAX);
        eq_s        = (cnt_r == last_r);
        match_nxt_s = next_match(match_r, eq_s);
    end

    // Period counter: restarts at 1 on each edge so its value at the next edge is the distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (!cnt_max_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Measurement FSM; an edge takes priority over a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            match_r      <= {MATCH_W{1'b0}};
            last_r       <= {CNT_W{1'b0}};
            period_r     <= {CNT_W{1'b0}};
            period_vld_r <= 1'b0;
            ratio_r      <= {CNT_W{1'b0}};
            locked_r     <= 1'b0;
            lost_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            period_vld_r <= 1'b0;
            lost_r       <= 1'b0;
            if (rise_s) begin
                case (state_r)
                    IDLE: begin
                        state_r   <= ACQ;
                        match_r   <= {MATCH_W{1'b0}};
                        last_r    <= {CNT_W{1'b0}};
                        timeout_r <= 1'b0;
                    end
                    ACQ: begin
                        period_r     <= cnt_r;
                        period_vld_r <= 1'b1;
                        match_r      <= match_nxt_s;
                        last_r       <= cnt_r;
                        if (match_nxt_s == LOCK_MATCH) begin
                            state_r  <= LOCK;
                            locked_r <= 1'b1;
                            ratio_r  <= cnt_r;
                        end else begin
                            state_r  <= ACQ;
                        end
                    end
                    LOCK: begin
                        period_r     <= cnt_r;
                        period_vld_r <= 1'b1;
                        if (!eq_s) begin
                            state_r  <= ACQ;
                            match_r  <= MATCH_W'(1);
                            last_r   <= cnt_r;
                            locked_r <= 1'b0;
                            lost_r   <= 1'b1;
                        end else begin
                            state_r  <= LOCK;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        match_r  <= {MATCH_W{1'b0}};
                        locked_r <= 1'b0;
                    end
                endcase
            end else if (cnt_max_s) begin
                state_r   <= IDLE;
                match_r   <= {MATCH_W{1'b0}};
                locked_r  <= 1'b0;
                timeout_r <= 1'b1;
                lost_r    <= (state_r == LOCK);
            end else begin
                state_r   <= state_r;
            end
        end
    end

    assign period     = period_r;
    assign period_vld = period_vld_r;
    assign ratio      = ratio_r;
    assign locked     = locked_r;
    assign lost       = lost_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_div_detect.sv
// Directed bench for clk_div_detect: table of steady ratios plus hand-built corner sequences.
module tb_clk_div_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] period;
    logic       period_vld;
    logic [7:0] ratio;
    logic       locked;
    logic       lost;
    logic       timeout;

    clk_div_detect #(.CNT_W(8), .LOCK_CNT(4), .TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .period     (period),
        .period_vld (period_vld),
        .ratio      (ratio),
        .locked     (locked),
        .lost       (lost),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int np;
        int per;
        int lock_at;
        int rat;
    } vec_t;

    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;
    int   lost_total;
    bit   tmo_seen;
    int   ph;
    int   q_per[$];
    int   q_lk[$];
    int   q_lost[$];
    int   q_rat[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (period_vld === 1'b1) begin
            q_per.push_back(int'(period));
            q_lk.push_back(int'(locked));
            q_lost.push_back(int'(lost));
            q_rat.push_back(int'(ratio));
        end
        if (lost === 1'b1) lost_total++;
        if (timeout === 1'b1) tmo_seen = 1'b1;
    endtask

    task automatic clear_log();
        q_per.delete();
        q_lk.delete();
        q_lost.delete();
        q_rat.delete();
        lost_total = 0;
        tmo_seen   = 1'b0;
        ph         = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {12'd0, period, period_vld, ratio, locked, lost, timeout}, 32'd0);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            din = lvl;
            tick();
        end
    endtask

    // Square wave hi/lo; runs until np new pulses and the pattern returns to phase 0.
    task automatic wave(input int hi, input int lo, input int np);
        int start;
        int cyc;
        start = q_per.size();
        cyc   = 0;
        while (((q_per.size() - start) < np || ph != 0) && cyc < 4000) begin
            din = (ph < hi);
            tick();
            ph = (ph + 1) % (hi + lo);
            cyc++;
        end
        chk("wave_pulse_count_reached", 32'((q_per.size() - start) >= np), 32'd1);
    endtask

    initial begin
        int j_tmo;
        int j_lost;
        int n0;
        rst = 1'b1;
        din = 1'b0;
        clear_log();

        vecs[0] = '{hi: 2, lo: 2, np: 6, per: 4, lock_at: 4, rat: 4};
        vecs[1] = '{hi: 1, lo: 1, np: 6, per: 2, lock_at: 4, rat: 2};
        vecs[2] = '{hi: 4, lo: 4, np: 5, per: 8, lock_at: 4, rat: 8};
        vecs[3] = '{hi: 3, lo: 2, np: 5, per: 5, lock_at: 4, rat: 5};

        for (int r = 0; r < 4; r++) begin
            do_reset();
            wave(vecs[r].hi, vecs[r].lo, vecs[r].np);
            for (int k = 0; k < vecs[r].np; k++) begin
                chk($sformatf("v%0d_period_%0d", r, k), 32'(q_per[k]), 32'(vecs[r].per));
                chk($sformatf("v%0d_locked_%0d", r, k), 32'(q_lk[k]),
                    32'((k + 1) >= vecs[r].lock_at));
            end
            chk($sformatf("v%0d_ratio", r), 32'(q_rat[vecs[r].np - 1]), 32'(vecs[r].rat));
            chk($sformatf("v%0d_no_lost", r), 32'(lost_total), 32'd0);
        end

        // Lock at 4, then switch to clk/8 and relock.
        do_reset();
        wave(2, 2, 5);
        wave(4, 4, 5);
        chk("sw_per5", 32'(q_per[5]), 32'd4);
        chk("sw_lk5", 32'(q_lk[5]), 32'd1);
        chk("sw_per6", 32'(q_per[6]), 32'd8);
        chk("sw_lost6", 32'(q_lost[6]), 32'd1);
        chk("sw_lk6", 32'(q_lk[6]), 32'd0);
        chk("sw_ratio_held6", 32'(q_rat[6]), 32'd4);
        chk("sw_lk8", 32'(q_lk[8]), 32'd0);
        chk("sw_lk9", 32'(q_lk[9]), 32'd1);
        chk("sw_ratio9", 32'(q_rat[9]), 32'd8);
        chk("sw_lost_total", 32'(lost_total), 32'd1);

        // Lock, then hold din low until timeout; a single rise clears it and only re-arms.
        do_reset();
        wave(2, 2, 5);
        n0     = q_per.size();
        j_tmo  = 0;
        j_lost = 0;
        for (int j = 1; j <= 300; j++) begin
            din = 1'b0;
            tick();
            if (timeout === 1'b1 && j_tmo == 0) j_tmo = j;
            if (lost === 1'b1 && j_lost == 0) j_lost = j;
        end
        chk("tmo_tick", 32'(j_tmo), 32'd254);
        chk("tmo_lost_tick", 32'(j_lost), 32'd254);
        chk("tmo_lost_total", 32'(lost_total), 32'd1);
        chk("tmo_locked", 32'(locked), 32'd0);
        chk("tmo_ratio_held", 32'(ratio), 32'd4);
        din = 1'b1;
        tick();
        tick();
        chk("tmo_still_set", 32'(timeout), 32'd1);
        tick();
        chk("tmo_cleared", 32'(timeout), 32'd0);
        tick();
        tick();
        chk("tmo_rearm_no_vld", 32'(q_per.size()), 32'(n0));

        // Edge lands exactly when the counter saturates: reported as period 255.
        do_reset();
        hold(1'b1, 3);
        hold(1'b0, 252);
        hold(1'b1, 4);
        chk("sat_count", 32'(q_per.size()), 32'd1);
        chk("sat_period", 32'(q_per[0]), 32'd255);
        chk("sat_no_timeout", 32'(tmo_seen), 32'd0);

        // Alternating 4,5 periods never lock.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
            hold(1'b1, 2);
            hold(1'b0, 3);
        end
        hold(1'b1, 3);
        chk("alt_count", 32'(q_per.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("alt_period_%0d", k), 32'(q_per[k]), 32'((k % 2 == 0) ? 4 : 5));
            chk($sformatf("alt_locked_%0d", k), 32'(q_lk[k]), 32'd0);
        end
        chk("alt_no_lost", 32'(lost_total), 32'd0);

        // Reset while locked: silent abort, then arm plus four matches to relock.
        do_reset();
        wave(2, 2, 5);
        chk("rl_locked_before", 32'(locked), 32'd1);
        rst = 1'b1;
        din = 1'b0;
        tick();
        chk("rl_outputs_zero", {12'd0, period, period_vld, ratio, locked, lost, timeout}, 32'd0);
        chk("rl_no_lost", 32'(lost_total), 32'd0);
        rst = 1'b0;
        clear_log();
        wave(2, 2, 4);
        chk("rl_per0", 32'(q_per[0]), 32'd4);
        chk("rl_lk2", 32'(q_lk[2]), 32'd0);
        chk("rl_lk3", 32'(q_lk[3]), 32'd1);
        chk("rl_ratio3", 32'(q_rat[3]), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
